// File: rtl/dtree_mc.sv
`default_nettype none
// ============================================================================
// Module   : dtree_mc
// Brief    : Multi-channel programmable decision-tree classifier, single-MAC datapath
// Revision : 1.0
// ============================================================================
module dtree_mc #(
  parameter int FEATURES    = 3,
  parameter int DEPTH       = 3,
  parameter int IN_WIDTH    = 10,
  parameter int COEFF_WIDTH = 4,
  parameter int CHANNELS    = 2,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int IDX_W      = $clog2(FEATURES + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_channel,
  input  logic [DEPTH-1:0]    cfg_node,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [IN_WIDTH-1:0] cfg_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH_W-1:0]     in_channel,
  input  logic [IN_WIDTH-1:0] in_sample,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH_W-1:0]     out_channel,
  output logic [DEPTH-1:0]    out_class
);

  localparam int NODES  = (1 << DEPTH) - 1;
  localparam int ACC_W  = IN_WIDTH + $clog2(FEATURES + 1) + 1;
  localparam int TERM_W = IN_WIDTH + 1;
  localparam int PROD_W = IN_WIDTH + COEFF_WIDTH;
  localparam int LVL_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_EVAL    = 2'd1,
    S_OUT     = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  logic signed [COEFF_WIDTH-1:0] r_coeff [CHANNELS][NODES][FEATURES];
  logic signed [IN_WIDTH-1:0]    r_bias  [CHANNELS][NODES];
  logic signed [IN_WIDTH-1:0]    r_vec   [FEATURES];

  logic [IDX_W-1:0]        r_beat;
  logic [IDX_W-1:0]        r_feat;
  logic [LVL_W-1:0]        r_level;
  logic [DEPTH-1:0]        r_node;
  logic [CH_W-1:0]         r_channel;
  logic [DEPTH-1:0]        r_class;
  logic signed [ACC_W-1:0] r_acc;

  logic                     w_cfg_ok;
  logic                     w_last_beat;
  logic                     w_last_feat;
  logic                     w_last_level;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [TERM_W-1:0] w_term;
  logic signed [ACC_W-1:0]  w_acc_base;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic                     w_dir;
  logic [DEPTH-1:0]         w_node_next;
  logic [DEPTH:0]           w_class_shift;

  assign w_last_beat  = (r_beat == IDX_W'(FEATURES - 1));
  assign w_last_feat  = (r_feat == IDX_W'(FEATURES - 1));
  assign w_last_level = (r_level == LVL_W'(DEPTH - 1));

  // Q1.(COEFF_WIDTH-1) product rescaled with floor semantics, then sign-extended.
  assign w_prod        = r_vec[r_feat] * r_coeff[r_channel][r_node][r_feat];
  assign w_term        = TERM_W'(w_prod >>> (COEFF_WIDTH - 1));
  assign w_acc_base    = (r_feat == '0) ? ACC_W'(r_bias[r_channel][r_node]) : r_acc;
  assign w_acc_next    = w_acc_base + ACC_W'(w_term);
  assign w_dir         = ~w_acc_next[ACC_W-1];
  assign w_node_next   = (r_node << 1) + DEPTH'(1) + DEPTH'(w_dir);
  assign w_class_shift = {r_class, w_dir};

  assign w_cfg_ok = cfg_we && cfg_ready
                    && (int'(cfg_channel) < CHANNELS)
                    && (int'(cfg_node) < NODES)
                    && (int'(cfg_idx) <= FEATURES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    cfg_ready    = 1'b0;
    case (r_state)
      S_COLLECT: begin
        in_ready  = 1'b1;
        cfg_ready = (r_beat == '0);
        if (in_valid && w_last_beat) w_state_next = S_EVAL;
      end
      S_EVAL: begin
        if (w_last_feat && w_last_level) w_state_next = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_COLLECT;
      end
      default: w_state_next = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_beat    <= '0;
      r_feat    <= '0;
      r_level   <= '0;
      r_node    <= '0;
      r_channel <= '0;
      r_class   <= '0;
      r_acc     <= '0;
      for (int f = 0; f < FEATURES; f++) r_vec[f] <= '0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          if (in_valid) begin
            r_vec[r_beat] <= in_sample;
            if (r_beat == '0) r_channel <= in_channel;
            if (w_last_beat) begin
              r_beat  <= '0;
              r_feat  <= '0;
              r_level <= '0;
              r_node  <= '0;
            end else begin
              r_beat <= r_beat + IDX_W'(1);
            end
          end
        end
        S_EVAL: begin
          r_acc <= w_acc_next;
          if (w_last_feat) begin
            r_feat  <= '0;
            r_level <= r_level + LVL_W'(1);
            r_node  <= w_node_next;
            r_class <= w_class_shift[DEPTH-1:0];
          end else begin
            r_feat <= r_feat + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Tree memory is cleared on reset so an aborted run never leaks old programming.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int n = 0; n < NODES; n++) begin
          r_bias[c][n] <= '0;
          for (int f = 0; f < FEATURES; f++) r_coeff[c][n][f] <= '0;
        end
      end
    end else if (w_cfg_ok) begin
      if (int'(cfg_idx) == FEATURES) begin
        r_bias[cfg_channel][cfg_node] <= cfg_data;
      end else begin
        r_coeff[cfg_channel][cfg_node][cfg_idx] <= cfg_data[COEFF_WIDTH-1:0];
      end
    end
  end

  assign out_channel = r_channel;
  assign out_class   = r_class;

endmodule
`default_nettype wire

// File: tb/tb_dtree_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_dtree_mc
// Brief    : Directed self-checking bench for dtree_mc at default parameters
// Revision : 1.0
// ============================================================================
module tb_dtree_mc;

  localparam int FEATURES    = 3;
  localparam int DEPTH       = 3;
  localparam int IN_WIDTH    = 10;
  localparam int COEFF_WIDTH = 4;
  localparam int CHANNELS    = 2;
  localparam int CH_W        = 1;
  localparam int IDX_W       = 2;

  logic                clk;
  logic                reset;
  logic                cfg_we;
  logic                cfg_ready;
  logic [CH_W-1:0]     cfg_channel;
  logic [DEPTH-1:0]    cfg_node;
  logic [IDX_W-1:0]    cfg_idx;
  logic [IN_WIDTH-1:0] cfg_data;
  logic                in_valid;
  logic                in_ready;
  logic [CH_W-1:0]     in_channel;
  logic [IN_WIDTH-1:0] in_sample;
  logic                out_valid;
  logic                out_ready;
  logic [CH_W-1:0]     out_channel;
  logic [DEPTH-1:0]    out_class;

  int n_cmp = 0;
  int n_bad = 0;

  dtree_mc #(
    .FEATURES(FEATURES), .DEPTH(DEPTH), .IN_WIDTH(IN_WIDTH),
    .COEFF_WIDTH(COEFF_WIDTH), .CHANNELS(CHANNELS)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_channel(cfg_channel),
    .cfg_node(cfg_node), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_channel(in_channel),
    .in_sample(in_sample), .out_valid(out_valid), .out_ready(out_ready),
    .out_channel(out_channel), .out_class(out_class)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b0; cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_channel = '0; cfg_node = '0; cfg_idx = '0; cfg_data = '0;
    in_channel = '0; in_sample = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input int ch, input int node, input int idx, input int data);
    cfg_we = 1'b1; cfg_channel = CH_W'(ch); cfg_node = DEPTH'(node);
    cfg_idx = IDX_W'(idx); cfg_data = IN_WIDTH'(data);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Later beats carry the opposite tag, which the DUT must ignore.
  task automatic send_vector(input int ch, input int x0, input int x1, input int x2);
    in_valid = 1'b1; in_channel = CH_W'(ch); in_sample = IN_WIDTH'(x0);
    @(posedge clk); #1;
    in_channel = ~CH_W'(ch); in_sample = IN_WIDTH'(x1);
    @(posedge clk); #1;
    in_sample = IN_WIDTH'(x2);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_channel = '0; cfg_node = '0; cfg_idx = '0; cfg_data = '0;
    in_channel = '0; in_sample = '0;
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_class !== 3'b000) begin n_bad++; $display("FAIL reset_out_class: got %b want 000", out_class); end
    n_cmp++; if (out_channel !== 1'b0) begin n_bad++; $display("FAIL reset_out_channel: got %b want 0", out_channel); end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
  endtask

  task automatic test_zero_memory();
    int lat;
    do_reset();
    send_vector(0, 5, -3, 7);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL eval_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL eval_cfg_ready: got %b want 0", cfg_ready); end
    wait_out(lat);
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL latency: got %0d want 10", lat); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL zero_out_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_class !== 3'b111) begin n_bad++; $display("FAIL zero_class: got %b want 111", out_class); end
    n_cmp++; if (out_channel !== 1'b0) begin n_bad++; $display("FAIL zero_channel: got %b want 0", out_channel); end
    consume();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL zero_after_consume_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL zero_after_consume_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_root_coeff();
    int lat;
    do_reset();
    cfg_write(0, 0, 0, 4);
    cfg_write(0, 0, 3, -10);
    send_vector(0, 20, 0, 0);          // -10 + (80>>>3=10) = 0 -> right
    wait_out(lat);
    n_cmp++; if (out_class !== 3'b111) begin n_bad++; $display("FAIL root_x20: got %b want 111", out_class); end
    consume();
    send_vector(0, 19, 0, 0);          // -10 + (76>>>3=9) = -1 -> left
    wait_out(lat);
    n_cmp++; if (out_class !== 3'b011) begin n_bad++; $display("FAIL root_x19: got %b want 011", out_class); end
    consume();
    cfg_write(0, 0, 3, 9);
    send_vector(0, -19, 0, 0);         // 9 + floor(-76/8)=-10 -> -1 -> left
    wait_out(lat);
    n_cmp++; if (out_class !== 3'b011) begin n_bad++; $display("FAIL root_floor_neg: got %b want 011", out_class); end
    consume();
  endtask

  task automatic test_channels();
    int lat;
    do_reset();
    cfg_write(1, 0, 3, -1);
    send_vector(1, 0, 0, 0);
    wait_out(lat);
    n_cmp++; if (out_class !== 3'b011) begin n_bad++; $display("FAIL ch1_class: got %b want 011", out_class); end
    n_cmp++; if (out_channel !== 1'b1) begin n_bad++; $display("FAIL ch1_channel: got %b want 1", out_channel); end
    consume();
    send_vector(0, 0, 0, 0);
    wait_out(lat);
    n_cmp++; if (out_class !== 3'b111) begin n_bad++; $display("FAIL ch0_class: got %b want 111", out_class); end
    n_cmp++; if (out_channel !== 1'b0) begin n_bad++; $display("FAIL ch0_channel: got %b want 0", out_channel); end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    do_reset();
    cfg_write(1, 0, 3, -1);
    send_vector(1, 0, 0, 0);
    wait_out(lat);
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_class !== 3'b011 || out_channel !== 1'b1 ||
          in_ready !== 1'b0 || cfg_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got v=%b cls=%b ch=%b ir=%b cr=%b want 1 011 1 0 0",
                 k, out_valid, out_class, out_channel, in_ready, cfg_ready);
      end
      if (k == 2) begin
        cfg_we = 1'b1; cfg_channel = 1'b0; cfg_node = 3'd0; cfg_idx = 2'd3; cfg_data = 10'h3FF;
      end
      @(posedge clk); #1;
      cfg_we = 1'b0;
    end
    consume();
    cfg_write(0, 7, 3, -1);            // node 7 is out of range
    send_vector(0, 0, 0, 0);
    wait_out(lat);
    n_cmp++; if (out_class !== 3'b111) begin n_bad++; $display("FAIL dropped_writes: got %b want 111", out_class); end
    consume();
  endtask

  task automatic test_extreme();
    int lat;
    do_reset();
    for (int n = 0; n < 7; n++) begin
      for (int i = 0; i < 3; i++) cfg_write(0, n, i, 8);   // code 1000 = -8
      cfg_write(0, n, 3, 511);
    end
    send_vector(0, -512, -512, -512);  // 511 + 3*512 = 2047 -> right
    wait_out(lat);
    n_cmp++; if (out_class !== 3'b111) begin n_bad++; $display("FAIL extreme_pos: got %b want 111", out_class); end
    consume();
    for (int n = 0; n < 7; n++)
      for (int i = 0; i < 3; i++) cfg_write(0, n, i, 7);
    send_vector(0, -512, -512, -512);  // 511 + 3*(-448) = -833 -> left
    wait_out(lat);
    n_cmp++; if (out_class !== 3'b000) begin n_bad++; $display("FAIL extreme_neg: got %b want 000", out_class); end
    consume();
  endtask

  task automatic test_abort();
    int lat;
    bit seen;
    do_reset();
    cfg_write(0, 0, 3, -10);
    send_vector(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid_in_reset: got %b want 0", out_valid); end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL abort_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL abort_cfg_ready: got %b want 1", cfg_ready); end
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_result: got %b want 0", seen); end
    send_vector(0, 0, 0, 0);
    wait_out(lat);
    n_cmp++; if (out_class !== 3'b111) begin n_bad++; $display("FAIL abort_mem_cleared: got %b want 111", out_class); end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_channel = 1'b0; in_sample = '0;
    cfg_we = 1'b1; cfg_channel = 1'b0; cfg_node = 3'd0; cfg_idx = 2'd3; cfg_data = 10'h3FF;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    n_cmp++; if (out_class !== 3'b011) begin n_bad++; $display("FAIL simul_cfg_beat: got %b want 011", out_class); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL one_cycle_handshake: got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_memory();
    test_root_coeff();
    test_channels();
    test_backpressure();
    test_extreme();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
